autoc_corr_win: RTL and testbench

//  Parametrised delay-and-correlate engine for the RX DDC path (packet/preamble detection).
//  Per input sample it computes the windowed complex lag product P(n) = sum_{k<WIN} x(n-k)*conj(x(n-k-LAG)).
//  It also computes the windowed energy R(n) = sum_{k<WIN} |x(n-k)|^2 and a threshold detect flag.

---
 rtl/autoc_corr_win.sv | 162 ++++++++++++++++
 tb/tb_autoc_corr_win.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/autoc_corr_win.sv
// Windowed delay-and-correlate engine: lag product P(n), energy R(n) and a threshold
// detect flag over a 2**LOG2_WIN moving window. Three register stages, one sample per strobe.
module autoc_corr_win #(
   parameter int WIDTH    = 16,
   parameter int LAG      = 16,
   parameter int LOG2_WIN = 5,
   parameter int OWIDTH   = 2*WIDTH+2+LOG2_WIN
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     in_stb,
   input  logic [2*WIDTH-1:0]       in_sample,
   input  logic [3:0]               thresh_shift,
   output logic                     out_stb,
   output logic signed [OWIDTH-1:0] corr_i,
   output logic signed [OWIDTH-1:0] corr_q,
   output logic signed [OWIDTH-1:0] energy,
   output logic                     det
);
   localparam int WIN  = 2**LOG2_WIN;
   localparam int PW   = 2*WIDTH+1;
   localparam int FILL = LAG+WIN;
   localparam int CW   = $clog2(FILL+1);

   logic [2*WIDTH-1:0]     r_lag [LAG];
   logic signed [PW-1:0]   r_dpr [WIN];
   logic signed [PW-1:0]   r_dpi [WIN];
   logic signed [PW-1:0]   r_dpe [WIN];
   logic [CW-1:0]          r_cnt;
   logic                   r_v1, r_e1, r_e2;
   logic signed [PW-1:0]   r_pr, r_pi, r_pe;
   logic signed [OWIDTH-1:0] r_acc_i, r_acc_q, r_acc_e;

   logic signed [PW-1:0]   w_i, w_q, w_id, w_qd;
   logic signed [PW-1:0]   w_pr, w_pi, w_pe;
   logic [2*WIDTH-1:0]     w_xd;
   logic                   w_full_next;
   logic signed [OWIDTH-1:0] w_new_i, w_new_q, w_new_e;
   logic signed [OWIDTH-1:0] w_old_i, w_old_q, w_old_e;
   logic signed [OWIDTH-1:0] w_thr;

   // Operands widened to product width up front so every multiply is exact.
   assign w_xd  = r_lag[LAG-1];
   assign w_i   = {{(PW-WIDTH){in_sample[2*WIDTH-1]}}, in_sample[2*WIDTH-1:WIDTH]};
   assign w_q   = {{(PW-WIDTH){in_sample[WIDTH-1]}},   in_sample[WIDTH-1:0]};
   assign w_id  = {{(PW-WIDTH){w_xd[2*WIDTH-1]}},      w_xd[2*WIDTH-1:WIDTH]};
   assign w_qd  = {{(PW-WIDTH){w_xd[WIDTH-1]}},        w_xd[WIDTH-1:0]};
   assign w_pr  = w_i*w_id + w_q*w_qd;
   assign w_pi  = w_q*w_id - w_i*w_qd;
   assign w_pe  = w_i*w_i  + w_q*w_q;

   assign w_full_next = (r_cnt >= CW'(FILL-1));

   assign w_new_i = {{(OWIDTH-PW){r_pr[PW-1]}}, r_pr};
   assign w_new_q = {{(OWIDTH-PW){r_pi[PW-1]}}, r_pi};
   assign w_new_e = {{(OWIDTH-PW){r_pe[PW-1]}}, r_pe};
   assign w_old_i = {{(OWIDTH-PW){r_dpr[WIN-1][PW-1]}}, r_dpr[WIN-1]};
   assign w_old_q = {{(OWIDTH-PW){r_dpi[WIN-1][PW-1]}}, r_dpi[WIN-1]};
   assign w_old_e = {{(OWIDTH-PW){r_dpe[WIN-1][PW-1]}}, r_dpe[WIN-1]};

   assign w_thr = r_acc_e >>> thresh_shift;

   // Lag line and fill counter: advance on accepted strobes only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LAG; k++) r_lag[k] <= '0;
         r_cnt <= '0;
      end else if (clear) begin
         for (int k = 0; k < LAG; k++) r_lag[k] <= '0;
         r_cnt <= '0;
      end else if (in_stb) begin
         r_lag[0] <= in_sample;
         for (int k = 1; k < LAG; k++) r_lag[k] <= r_lag[k-1];
         if (r_cnt != CW'(FILL)) r_cnt <= r_cnt + 1'b1;
      end
   end

   // Stage 1: products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v1 <= 1'b0;
         r_e1 <= 1'b0;
         r_pr <= '0;
         r_pi <= '0;
         r_pe <= '0;
      end else if (clear) begin
         r_v1 <= 1'b0;
         r_e1 <= 1'b0;
         r_pr <= '0;
         r_pi <= '0;
         r_pe <= '0;
      end else begin
         r_v1 <= in_stb;
         r_e1 <= in_stb & w_full_next;
         if (in_stb) begin
            r_pr <= w_pr;
            r_pi <= w_pi;
            r_pe <= w_pe;
         end
      end
   end

   // Stage 2: product delay line and moving sums.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < WIN; k++) begin
            r_dpr[k] <= '0;
            r_dpi[k] <= '0;
            r_dpe[k] <= '0;
         end
         r_acc_i <= '0;
         r_acc_q <= '0;
         r_acc_e <= '0;
         r_e2    <= 1'b0;
      end else if (clear) begin
         for (int k = 0; k < WIN; k++) begin
            r_dpr[k] <= '0;
            r_dpi[k] <= '0;
            r_dpe[k] <= '0;
         end
         r_acc_i <= '0;
         r_acc_q <= '0;
         r_acc_e <= '0;
         r_e2    <= 1'b0;
      end else begin
         r_e2 <= r_e1;
         if (r_v1) begin
            r_dpr[0] <= r_pr;
            r_dpi[0] <= r_pi;
            r_dpe[0] <= r_pe;
            for (int k = 1; k < WIN; k++) begin
               r_dpr[k] <= r_dpr[k-1];
               r_dpi[k] <= r_dpi[k-1];
               r_dpe[k] <= r_dpe[k-1];
            end
            r_acc_i <= r_acc_i + w_new_i - w_old_i;
            r_acc_q <= r_acc_q + w_new_q - w_old_q;
            r_acc_e <= r_acc_e + w_new_e - w_old_e;
         end
      end
   end

   // Stage 3: output registers; data outputs hold between strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_stb <= 1'b0;
         corr_i  <= '0;
         corr_q  <= '0;
         energy  <= '0;
         det     <= 1'b0;
      end else begin
         out_stb <= r_e2 & ~clear;
         if (r_e2 && !clear) begin
            corr_i <= r_acc_i;
            corr_q <= r_acc_q;
            energy <= r_acc_e;
            det    <= (r_acc_i > w_thr);
         end
      end
   end
endmodule

// File: tb/tb_autoc_corr_win.sv
// Directed bench for autoc_corr_win: DC, rotating, full-scale, gapped, clear, noise and reset cases.
module tb_autoc_corr_win;
   localparam int OW = 39;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 clear;
   logic                 in_stb;
   logic [31:0]          in_sample;
   logic [3:0]           thresh_shift;
   logic                 out_stb, out_stb17;
   logic signed [OW-1:0] corr_i, corr_q, energy;
   logic signed [OW-1:0] corr_i17, corr_q17, energy17;
   logic                 det, det17;

   int n_chk  = 0;
   int n_fail = 0;
   int n_out  = 0;
   int n_out17 = 0;
   int n_det  = 0;
   int base, base17, dbase;

   localparam longint E32M = 64'sd32000000;
   localparam longint E236 = 64'sd68719476736;

   always #5 clk = ~clk;

   autoc_corr_win #(.WIDTH(16), .LAG(16), .LOG2_WIN(5)) u_dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_stb(in_stb), .in_sample(in_sample),
      .thresh_shift(thresh_shift), .out_stb(out_stb), .corr_i(corr_i), .corr_q(corr_q),
      .energy(energy), .det(det)
   );

   autoc_corr_win #(.WIDTH(16), .LAG(17), .LOG2_WIN(5)) u_dut17 (
      .clk(clk), .rst_n(rst_n), .clear(clear), .in_stb(in_stb), .in_sample(in_sample),
      .thresh_shift(thresh_shift), .out_stb(out_stb17), .corr_i(corr_i17), .corr_q(corr_q17),
      .energy(energy17), .det(det17)
   );

   always @(negedge clk) begin
      if (out_stb) begin
         n_out++;
         if (det) n_det++;
      end
      if (out_stb17) n_out17++;
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic signed [15:0] i, input logic signed [15:0] q);
      @(negedge clk);
      in_stb    = 1'b1;
      in_sample = {i, q};
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         in_stb = 1'b0;
      end
   endtask

   task automatic do_clear();
      @(negedge clk);
      in_stb = 1'b0;
      clear  = 1'b1;
      @(negedge clk);
      clear  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic signed [15:0] ri, rq;
      rst_n = 1'b0; clear = 1'b0; in_stb = 1'b0; in_sample = '0; thresh_shift = 4'd1;
      repeat (3) @(negedge clk);
      chk("reset_out_stb", out_stb, 0);
      chk("reset_corr_i", corr_i, 0);
      chk("reset_corr_q", corr_q, 0);
      chk("reset_energy", energy, 0);
      chk("reset_det", det, 0);
      rst_n = 1'b1;

      // DC input, strobe every cycle; first result on strobe 48, three cycles later
      base = n_out;
      repeat (47) strobe(16'sd1000, 16'sd0);
      idle(4);
      chk("dc_no_early_out", n_out - base, 0);
      strobe(16'sd1000, 16'sd0);
      idle(1);
      chk("dc_lat_c1", out_stb, 0);
      idle(1);
      chk("dc_lat_c2", out_stb, 0);
      idle(1);
      chk("dc_lat_c3", out_stb, 1);
      chk("dc_corr_i", corr_i, E32M);
      chk("dc_corr_q", corr_q, 0);
      chk("dc_energy", energy, E32M);
      chk("dc_det_shift1", det, 1);
      repeat (20) strobe(16'sd1000, 16'sd0);
      idle(4);
      chk("dc_out_count", n_out - base, 21);
      chk("dc_corr_i_steady", corr_i, E32M);

      // Same stream with random gaps then every third cycle
      do_clear();
      base = n_out;
      for (int k = 0; k < 60; k++) begin
         strobe(16'sd1000, 16'sd0);
         if (k < 30) idle($urandom_range(0, 3));
         else        idle(2);
      end
      idle(5);
      chk("gap_out_count", n_out - base, 13);
      chk("gap_corr_i", corr_i, E32M);
      chk("gap_corr_q", corr_q, 0);
      chk("gap_energy", energy, E32M);
      chk("gap_det", det, 1);

      // clear coincident with strobe 60: strobes 58/59 in flight are dropped
      do_clear();
      base = n_out;
      repeat (59) strobe(16'sd1000, 16'sd0);
      @(negedge clk);
      in_stb = 1'b1; clear = 1'b1; in_sample = {16'sd1000, 16'sd0};
      @(negedge clk);
      in_stb = 1'b0; clear = 1'b0;
      idle(4);
      chk("clr_inflight_count", n_out - base, 10);
      base = n_out;
      repeat (47) strobe(16'sd1000, 16'sd0);
      idle(5);
      chk("clr_no_early_out", n_out - base, 0);
      strobe(16'sd1000, 16'sd0);
      idle(4);
      chk("clr_first_out", n_out - base, 1);
      chk("clr_corr_i", corr_i, E32M);
      chk("clr_energy", energy, E32M);

      // Rotating input 1000*j^n on LAG=16 and LAG=17
      do_clear();
      base = n_out; base17 = n_out17;
      for (int n = 0; n < 80; n++) begin
         case (n % 4)
            0: strobe(16'sd1000, 16'sd0);
            1: strobe(16'sd0, 16'sd1000);
            2: strobe(-16'sd1000, 16'sd0);
            default: strobe(16'sd0, -16'sd1000);
         endcase
      end
      idle(5);
      chk("rot16_count", n_out - base, 33);
      chk("rot16_corr_i", corr_i, E32M);
      chk("rot16_corr_q", corr_q, 0);
      chk("rot16_energy", energy, E32M);
      chk("rot17_count", n_out17 - base17, 32);
      chk("rot17_corr_i", corr_i17, 0);
      chk("rot17_corr_q", corr_q17, E32M);
      chk("rot17_energy", energy17, E32M);
      chk("rot17_det", det17, 0);

      // Full scale, thresh_shift=0: corr_i equals energy so det stays low
      thresh_shift = 4'd0;
      do_clear();
      base = n_out;
      repeat (100) strobe(-16'sd32768, -16'sd32768);
      idle(5);
      chk("fs_count", n_out - base, 53);
      chk("fs_energy", energy, E236);
      chk("fs_corr_i", corr_i, E236);
      chk("fs_corr_q", corr_q, 0);
      chk("fs_det_shift0", det, 0);

      // Noise-only +/-1 input: energy fixed at 64, no detects
      thresh_shift = 4'd1;
      do_clear();
      base = n_out; dbase = n_det;
      repeat (60) begin
         ri = ($urandom_range(0, 1) != 0) ? 16'sd1 : -16'sd1;
         rq = ($urandom_range(0, 1) != 0) ? 16'sd1 : -16'sd1;
         strobe(ri, rq);
      end
      idle(5);
      chk("noise_count", n_out - base, 13);
      chk("noise_energy", energy, 64);
      chk("noise_det_hits", n_det - dbase, 0);

      // Asynchronous reset mid-stream
      do_clear();
      repeat (60) strobe(16'sd1000, 16'sd0);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_stb", out_stb, 0);
      chk("arst_corr_i", corr_i, 0);
      chk("arst_energy", energy, 0);
      chk("arst_det", det, 0);
      @(negedge clk);
      in_stb = 1'b0; rst_n = 1'b1;
      base = n_out;
      repeat (47) strobe(16'sd1000, 16'sd0);
      idle(5);
      chk("arst_refill_none", n_out - base, 0);
      strobe(16'sd1000, 16'sd0);
      idle(4);
      chk("arst_refill_out", n_out - base, 1);
      chk("arst_refill_corr_i", corr_i, E32M);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
